countdown_sequencer: RTL and testbench



---
 rtl/countdown_sequencer.sv | 101 ++++++++++
 tb/tb_countdown_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// Loadable down counter with a start/done handshake for the multi-cycle ALU control.
// Optional auto-reload restarts from the last loaded value when done is acknowledged.
module countdown_sequencer #(
  parameter int WIDTH       = 3,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_down,
  input  logic             abort,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      count_reg  <= ZERO;
      reload_reg <= ZERO;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;

    if (abort) begin
      state_next = IDLE;
      count_next = ZERO;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            count_next  = load_value;
            reload_next = load_value;
            state_next  = (load_value != ZERO) ? RUN : DONE;
          end
        end
        RUN: begin
          if (count_down) begin
            // Saturate at the final step so the counter can never wrap.
            if (count_reg <= ONE) begin
              count_next = ZERO;
              state_next = DONE;
            end else begin
              count_next = count_reg - ONE;
            end
          end
        end
        DONE: begin
          if (load) begin
            count_next  = load_value;
            reload_next = load_value;
            state_next  = (load_value != ZERO) ? RUN : DONE;
          end else if (ack) begin
            if (AUTO_RELOAD != 0) begin
              count_next = reload_reg;
              state_next = (reload_reg != ZERO) ? RUN : DONE;
            end else begin
              count_next = ZERO;
              state_next = IDLE;
            end
          end
        end
        default: begin
          state_next = IDLE;
          count_next = ZERO;
        end
      endcase
    end
  end

  assign count = count_reg;
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);
  assign zero  = (count_reg == ZERO);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: two instances (plain and auto-reload) share stimulus
// and are compared each cycle against a behavioural model of remaining iterations.
module tb_countdown_sequencer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         count_down = 1'b0;
  logic         abort = 1'b0;
  logic         ack = 1'b0;

  logic [W-1:0] count0, count1;
  logic         busy0, done0, zero0, busy1, done1, zero1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: iterations remaining, whether running / finished, last loaded value.
  int rem_m [2];
  bit run_m [2];
  bit fin_m [2];
  int last_m[2];

  countdown_sequencer #(.WIDTH(W), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .resetn(resetn), .load(load), .load_value(load_value),
    .count_down(count_down), .abort(abort), .ack(ack),
    .count(count0), .busy(busy0), .done(done0), .zero(zero0)
  );

  countdown_sequencer #(.WIDTH(W), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .resetn(resetn), .load(load), .load_value(load_value),
    .count_down(count_down), .abort(abort), .ack(ack),
    .count(count1), .busy(busy1), .done(done1), .zero(zero1)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      rem_m[k] = 0; run_m[k] = 0; fin_m[k] = 0; last_m[k] = 0;
    end
  endfunction

  function automatic void model_update();
    for (int k = 0; k < 2; k++) begin
      if (abort) begin
        rem_m[k] = 0; run_m[k] = 0; fin_m[k] = 0;
      end else if (!run_m[k] && load) begin
        rem_m[k]  = int'(load_value);
        last_m[k] = int'(load_value);
        run_m[k]  = (rem_m[k] > 0);
        fin_m[k]  = (rem_m[k] == 0);
      end else if (fin_m[k] && ack) begin
        if (k == 1) begin
          rem_m[k] = last_m[k];
          run_m[k] = (rem_m[k] > 0);
          fin_m[k] = (rem_m[k] == 0);
        end else begin
          fin_m[k] = 0;
        end
      end else if (run_m[k] && count_down) begin
        rem_m[k] = rem_m[k] - 1;
        if (rem_m[k] == 0) begin
          run_m[k] = 0; fin_m[k] = 1;
        end
      end
    end
  endfunction

  function automatic logic [W+2:0] expv(int k);
    return {W'(rem_m[k]), run_m[k], fin_m[k], (rem_m[k] == 0)};
  endfunction

  function automatic logic [W+2:0] obs(int k);
    return (k == 0) ? {count0, busy0, done0, zero0} : {count1, busy1, done1, zero1};
  endfunction

  // Packed stimulus word: {load, load_value, count_down, abort, ack}
  function automatic logic [W+3:0] mk(logic l, logic [W-1:0] lv, logic cd, logic ab, logic ak);
    return {l, lv, cd, ab, ak};
  endfunction

  task automatic step(input logic [W+3:0] s);
    {load, load_value, count_down, abort, ack} = s;
    @(posedge clk);
    model_update();
    @(negedge clk);
    $display("t=%0t load=%b lv=%0d cd=%b abort=%b ack=%b | cnt0=%0d b0=%b d0=%b | cnt1=%0d b1=%b d1=%b",
             $time, load, load_value, count_down, abort, ack,
             count0, busy0, done0, count1, busy1, done1);
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (obs(k) !== 6'b000_0_0_1) $display("FAIL reset_init dut%0d got=%b exp=%b", k, obs(k), 6'b000001);
      else pass_cnt++;
    end
    model_reset();
    resetn = 1'b1;
    @(negedge clk);
    step(mk(1, 3'd5, 0, 0, 0));
    step(mk(0, 3'd0, 0, 0, 0));
    total_cnt++;
    if ({count0, busy0} !== {3'd5, 1'b1}) $display("FAIL reset_prerun got=%0d/%b exp=5/1", count0, busy0);
    else pass_cnt++;
    {load, load_value, count_down, abort, ack} = '0;
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (obs(k) !== 6'b000_0_0_1) $display("FAIL reset_async dut%0d got=%b exp=%b", k, obs(k), 6'b000001);
      else pass_cnt++;
    end
    model_reset();
    #1 resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W+3:0] seq [$];
    int cyc;
    step(mk(0, 3'd0, 0, 1, 0));
    step(mk(1, 3'd5, 1, 0, 0));
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 20) begin
      step(mk(0, 3'd0, 1, 0, 0));
      cyc++;
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs(k) !== expv(k)) $display("FAIL basic_run dut%0d got=%b exp=%b", k, obs(k), expv(k));
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (cyc !== 6) $display("FAIL basic_latency got=%0d exp=6", cyc);
    else pass_cnt++;
    seq = '{mk(0, 3'd0, 0, 0, 0), mk(0, 3'd0, 0, 0, 0), mk(0, 3'd0, 0, 0, 1), mk(0, 3'd0, 0, 0, 0)};
    foreach (seq[i]) begin
      step(seq[i]);
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs(k) !== expv(k)) $display("FAIL basic_ack dut%0d step=%0d got=%b exp=%b", k, i, obs(k), expv(k));
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({busy0, done0, count0} !== {1'b0, 1'b0, 3'd0}) $display("FAIL basic_idle got=%b%b%0d exp=000", busy0, done0, count0);
    else pass_cnt++;
  endtask

  task automatic test_gapped_max();
    step(mk(0, 3'd0, 0, 1, 0));
    step(mk(1, 3'd7, 0, 0, 0));
    for (int i = 0; i < 18; i++) begin
      step(mk(0, 3'd0, (i % 2 == 0), 0, 0));
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs(k) !== expv(k)) $display("FAIL gapped dut%0d step=%0d got=%b exp=%b", k, i, obs(k), expv(k));
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({done0, count0} !== {1'b1, 3'd0}) $display("FAIL gapped_nowrap got=%b/%0d exp=1/0", done0, count0);
    else pass_cnt++;
  endtask

  task automatic test_zero_load();
    logic [W+3:0] seq [$];
    seq = '{mk(0, 3'd0, 0, 1, 0), mk(1, 3'd0, 1, 0, 0), mk(0, 3'd0, 1, 0, 0),
            mk(1, 3'd3, 0, 0, 1), mk(0, 3'd0, 1, 0, 0)};
    foreach (seq[i]) begin
      step(seq[i]);
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs(k) !== expv(k)) $display("FAIL zero_load dut%0d step=%0d got=%b exp=%b", k, i, obs(k), expv(k));
        else pass_cnt++;
      end
      if (i == 2) begin
        total_cnt++;
        if ({busy0, done0} !== 2'b01) $display("FAIL zero_load_done got=%b exp=01", {busy0, done0});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_abort();
    logic [W+3:0] seq [$];
    seq = '{mk(0, 3'd0, 0, 1, 0), mk(1, 3'd6, 0, 0, 0), mk(0, 3'd0, 1, 0, 0),
            mk(0, 3'd0, 1, 0, 0), mk(1, 3'd5, 1, 1, 0), mk(0, 3'd0, 1, 0, 1)};
    foreach (seq[i]) begin
      step(seq[i]);
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs(k) !== expv(k)) $display("FAIL abort dut%0d step=%0d got=%b exp=%b", k, i, obs(k), expv(k));
        else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++;
        if ({count0, busy0, done0} !== 5'b000_0_0) $display("FAIL abort_idle got=%b exp=00000", {count0, busy0, done0});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [W+3:0] seq [$];
    seq = '{mk(0, 3'd0, 0, 1, 0), mk(1, 3'd2, 0, 0, 0), mk(1, 3'd6, 0, 0, 1),
            mk(0, 3'd0, 1, 0, 0), mk(0, 3'd0, 1, 0, 0), mk(0, 3'd0, 1, 0, 0),
            mk(0, 3'd0, 0, 0, 1), mk(0, 3'd0, 1, 0, 0), mk(0, 3'd0, 1, 0, 0),
            mk(0, 3'd0, 0, 1, 0), mk(1, 3'd0, 0, 0, 0), mk(0, 3'd0, 0, 0, 1)};
    foreach (seq[i]) begin
      step(seq[i]);
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs(k) !== expv(k)) $display("FAIL auto_reload dut%0d step=%0d got=%b exp=%b", k, i, obs(k), expv(k));
        else pass_cnt++;
      end
      if (i == 6) begin
        total_cnt++;
        if ({count1, busy1} !== {3'd2, 1'b1}) $display("FAIL auto_reload_restart got=%0d/%b exp=2/1", count1, busy1);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({done1, count1} !== {1'b1, 3'd0}) $display("FAIL auto_reload_zero got=%b/%0d exp=1/0", done1, count1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W+3:0] s;
    for (int i = 0; i < 300; i++) begin
      s = mk(($urandom_range(0, 3) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      step(s);
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (obs(k) !== expv(k)) $display("FAIL random dut%0d step=%0d got=%b exp=%b", k, i, obs(k), expv(k));
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_gapped_max();
    test_zero_load();
    test_abort();
    test_auto_reload();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
